// File: rtl/tree_loader_pkg.sv
// Shared types for the selector-tree loader: FSM states and the entry-count width helper.
package tree_loader_pkg;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    EVAL = 2'd1,
    HOLD = 2'd2
  } state_e;

  // Counter must represent NUM itself, not just NUM-1.
  function automatic int calc_cw(input int num);
    return $clog2(num + 1);
  endfunction

endpackage

// File: rtl/tree_loader.sv
// Serial loader for the selector tree; result valid one cycle after the closing entry.
// in_ready drops from frame close until the result handshake; in_valid is ignored meanwhile.
module tree_loader
  import tree_loader_pkg::*;
#(
  parameter int NUM = 4096,
  parameter int LEN = 16,
  parameter int CW  = calc_cw(NUM)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LEN-1:0]     in_data,
  input  logic               in_last,
  output logic [NUM*LEN-1:0] tree_in,
  input  logic [LEN-1:0]     tree_sum,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [LEN-1:0]     res_data,
  output logic               res_found,
  output logic [CW-1:0]      res_count
);

  localparam int PW = $clog2(NUM);

  state_e         state_q, state_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [LEN-1:0] res_data_q;
  logic           res_found_q;
  logic [CW-1:0]  res_count_q;
  logic           accept;
  logic           capture;
  logic           clear_slots;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    cnt_d       = cnt_q;
    in_ready    = 1'b0;
    accept      = 1'b0;
    capture     = 1'b0;
    clear_slots = 1'b0;
    case (state_q)
      FILL: begin
        in_ready = ~rst;
        accept   = in_valid & ~rst;
        if (accept) begin
          wr_ptr_d = wr_ptr_q + PW'(1);
          cnt_d    = cnt_q + CW'(1);
          if (in_last || wr_ptr_q == PW'(NUM - 1)) begin
            state_d = EVAL;
          end
        end
      end
      EVAL: begin
        capture = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (res_ready) begin
          clear_slots = 1'b1;
          wr_ptr_d    = '0;
          cnt_d       = '0;
          state_d     = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FILL;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      res_data_q  <= '0;
      res_found_q <= 1'b0;
      res_count_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      // Slots are frozen during EVAL, so tree_sum reflects the complete frame here.
      if (capture) begin
        res_data_q  <= tree_sum;
        res_found_q <= ~tree_sum[0];
        res_count_q <= cnt_q;
      end
    end
  end

  // Idle slots hold all-ones so their free flag never wins a selection.
  for (genvar i = 0; i < NUM; i++) begin : g_slot
    logic [LEN-1:0] slot_q;
    always_ff @(posedge clk) begin
      if (rst || clear_slots) begin
        slot_q <= '1;
      end else if (accept && wr_ptr_q == PW'(i)) begin
        slot_q <= in_data;
      end
    end
    assign tree_in[i*LEN +: LEN] = slot_q;
  end

  assign res_valid = (state_q == HOLD);
  assign res_data  = res_data_q;
  assign res_found = res_found_q;
  assign res_count = res_count_q;

endmodule

// File: tb/tb_tree_loader.sv
// Bench for tree_loader: reference tree, frame-level scoreboard, scripted and random traffic.
module tb_tree_loader;
  import tree_loader_pkg::*;

  localparam int NUM = 8;
  localparam int LEN = 16;
  localparam int CW  = $clog2(NUM + 1);
  localparam logic [NUM*LEN-1:0] ALL1 = '1;

  logic               clk = 1'b0;
  logic               rst, in_valid, in_last, res_ready;
  logic [LEN-1:0]     in_data;
  logic               in_ready, res_valid, res_found;
  logic [NUM*LEN-1:0] tree_in;
  logic [LEN-1:0]     tree_sum, res_data;
  logic [CW-1:0]      res_count;

  always #5 clk = ~clk;

  tree_loader #(.NUM(NUM), .LEN(LEN), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .tree_in(tree_in), .tree_sum(tree_sum),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_found(res_found), .res_count(res_count)
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Selector tree: leftmost entry with a clear free flag, else the rightmost entry.
  function automatic logic [LEN-1:0] select_first_free(input logic [NUM*LEN-1:0] v);
    logic [LEN-1:0] e;
    for (int i = 0; i < NUM; i++) begin
      e = v[i*LEN +: LEN];
      if (!e[0]) return e;
    end
    return v[NUM*LEN-1 -: LEN];
  endfunction

  assign tree_sum = select_first_free(tree_in);

  task automatic check(input string name, input logic [NUM*LEN-1:0] act,
                       input logic [NUM*LEN-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
  endtask

  // Frame-level model
  logic [LEN-1:0] m_slots[NUM];
  int             m_n = 0;
  bit             m_busy = 1'b0;
  int             m_close_cyc = 0;
  int             cyc = 0;
  logic [LEN-1:0] m_exp_data;
  bit             m_exp_found;
  int             m_exp_count;
  int             dut_last_hs = 0;
  int             dut_period = 0;

  function automatic logic [NUM*LEN-1:0] pack_slots();
    logic [NUM*LEN-1:0] v;
    for (int i = 0; i < NUM; i++) v[i*LEN +: LEN] = m_slots[i];
    return v;
  endfunction

  always @(posedge clk) begin
    bit rv_exp;
    rv_exp = m_busy && (cyc > m_close_cyc);
    if (res_valid && res_ready && !rst) begin
      dut_period  = cyc - dut_last_hs;
      dut_last_hs = cyc;
    end
    cyc++;
    if (rst) begin
      for (int i = 0; i < NUM; i++) m_slots[i] = '1;
      m_n    = 0;
      m_busy = 1'b0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_slots[m_n] = in_data;
        m_n++;
        if (in_last || m_n == NUM) begin
          m_busy      = 1'b1;
          m_close_cyc = cyc;
          m_exp_data  = select_first_free(pack_slots());
          m_exp_found = !m_exp_data[0];
          m_exp_count = m_n;
        end
      end
    end else if (rv_exp && res_ready) begin
      for (int i = 0; i < NUM; i++) m_slots[i] = '1;
      m_n    = 0;
      m_busy = 1'b0;
    end
  end

  always @(negedge clk) begin
    bit rv_exp;
    if (chk_en) begin
      rv_exp = m_busy && (cyc > m_close_cyc);
      check("in_ready", in_ready, !rst && !m_busy);
      check("res_valid", res_valid, rv_exp);
      check("tree_in", tree_in, pack_slots());
      if (rv_exp) begin
        check("res_data", res_data, m_exp_data);
        check("res_found", res_found, m_exp_found);
        check("res_count", res_count, m_exp_count);
      end
    end
  end

  task automatic send(input logic [LEN-1:0] d, input bit last);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        break;
      end
      guard++;
      if (guard > 100) begin
        timeout_fail("send");
        @(posedge clk);
        #1;
        break;
      end
    end
  endtask

  task automatic wait_rv();
    int guard;
    guard = 0;
    forever begin
      @(negedge clk);
      if (res_valid) break;
      guard++;
      if (guard > 100) begin
        timeout_fail("wait_rv");
        break;
      end
    end
  endtask

  initial begin
    logic [LEN-1:0]     vals[NUM];
    logic [NUM*LEN-1:0] tv;
    vals = '{16'h0003, 16'h0005, 16'h0008, 16'h0011, 16'h0020, 16'h0001, 16'h0002, 16'h0007};
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; res_ready = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_tree_in", tree_in, ALL1);
    check("idle_in_ready", in_ready, 1'b1);
    check("idle_res_valid", res_valid, 1'b0);
    check("idle_res_data", res_data, 16'h0000);
    @(posedge clk); #1;

    // Full frame without in_last
    res_ready = 1'b1;
    for (int i = 0; i < NUM; i++) send(vals[i], 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    check("t1_rv_in_eval", res_valid, 1'b0);
    @(negedge clk);
    check("t1_rv", res_valid, 1'b1);
    check("t1_data", res_data, 16'h0008);
    check("t1_found", res_found, 1'b1);
    check("t1_count", res_count, 8);
    @(posedge clk); #1;

    // Early close, nothing selectable
    send(16'h0001, 1'b0);
    send(16'h0003, 1'b0);
    send(16'h0009, 1'b1);
    in_valid = 1'b0; in_last = 1'b0;
    wait_rv();
    check("t2_data", res_data, 16'hFFFF);
    check("t2_found", res_found, 1'b0);
    check("t2_count", res_count, 3);
    tv = '0;
    tv[NUM*LEN-1-3*LEN:0] = tree_in[NUM*LEN-1:3*LEN];
    check("t2_upper_slots", tv, ALL1 >> (3*LEN));
    @(posedge clk); #1;

    // Result held under backpressure with in_valid asserted
    res_ready = 1'b0;
    for (int i = 0; i < NUM; i++) send(LEN'($urandom), 1'b0);
    wait_rv();
    for (int i = 0; i < 10; i++) begin
      check("t3_in_ready", in_ready, 1'b0);
      check("t3_rv", res_valid, 1'b1);
      @(negedge clk);
    end
    @(posedge clk); #1;
    res_ready = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("t3_in_ready_after", in_ready, 1'b1);
    check("t3_tree_cleared", tree_in, ALL1);
    @(posedge clk); #1;

    // Reset in the middle of a frame
    for (int i = 0; i < 4; i++) send(vals[i], 1'b0);
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("t4_tree_in", tree_in, ALL1);
    check("t4_in_ready", in_ready, 1'b0);
    check("t4_rv", res_valid, 1'b0);
    check("t4_res_data", res_data, 16'h0000);
    check("t4_res_count", res_count, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < NUM; i++) send(16'h0010, 1'b0);
    in_valid = 1'b0;
    wait_rv();
    check("t4_data", res_data, 16'h0010);
    check("t4_count", res_count, 8);
    @(posedge clk); #1;

    // Back-to-back frames
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < NUM; i++) send(LEN'($urandom), 1'b0);
    in_valid = 1'b0;
    wait_rv();
    @(posedge clk); #1;
    check("t5_period", dut_period, 10);

    // Random traffic with occasional reset
    for (int c = 0; c < 1500; c++) begin
      rst       = ($urandom_range(0, 199) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = LEN'($urandom) | LEN'($urandom_range(0, 3) != 0);
      in_last   = ($urandom_range(0, 5) == 0);
      res_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
    end
    rst = 1'b0; in_valid = 1'b0; in_last = 1'b0; res_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tree_loader.md
# tree_loader

Upstream feeder for the selector tree. Accepts LEN-bit entries serially over a valid/ready stream and packs them into the flat NUM*LEN vector that drives the tree's `in` port. The tree is purely combinational. Once a frame is loaded, this block holds the vector stable for one evaluation cycle, registers the tree's `sum` output, and presents it with a valid/ready result handshake.

## Interface
- NUM, 4096: entries per frame; must be a power of two, ≥2 (no odd-level padding inside the tree).
- LEN, 16: entry width; bit 0 is the "free" flag (0 = selectable).
- CW, $clog2(NUM+1): width of the entry count.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  entry offered.
- in_ready  out  1  entry accepted when in_valid && in_ready.
- in_data  in  LEN  entry payload.
- in_last  in  1  qualifies the accepted entry as the last of the frame (early close).
- tree_in  out  NUM*LEN  packed frame to the tree; entry i at [(i+1)*LEN-1 : i*LEN].
- tree_sum  in  LEN  tree combinational result.
- res_valid  out  1  result available.
- res_ready  in  1  result consumed when res_valid && res_ready.
- res_data  out  LEN  captured tree_sum.
- res_found  out  1  ~tree_sum[0] at capture; 0 means no selectable entry in the frame.
- res_count  out  CW  number of entries accepted in the frame (1..NUM).

## Operation
- Storage: NUM×LEN slot registers drive tree_in directly, so tree_in is always a registered value. Write pointer wr_ptr counts 0..NUM-1. Entry counter cnt has width CW.
- States: FILL, EVAL, HOLD.
- FILL: in_ready=1.
  - On each accept, write slot[wr_ptr]=in_data, increment wr_ptr and cnt.
  - Go to EVAL when the accept has in_last=1 or wr_ptr==NUM-1.
  - Slots not written keep all-ones (bit0=1), so unwritten slots are never selected.
- EVAL: in_ready=0; slots frozen. At the end of the cycle, capture res_data=tree_sum, res_found=~tree_sum[0], res_count=cnt+... (already updated cnt). Go to HOLD.
- HOLD: res_valid=1, in_ready=0.
  - On res handshake: set all slots to all-ones, wr_ptr=0, cnt=0, res_valid=0, go to FILL.
  - res_data, res_found and res_count stay stable until the handshake.
- in_valid outside FILL is ignored (not accepted, not stored).
- in_last on the NUM-th entry behaves the same as reaching NUM without in_last.
- A frame is never empty. EVAL is entered only after at least one accept.
- Reset: state=FILL, all slots all-ones (tree_in all ones), wr_ptr=0, cnt=0, res_valid=0, res_data=0, res_found=0, res_count=0. in_ready=0 while rst=1, and 1 in the first cycle after rst deasserts.
- Reset mid-frame or mid-HOLD discards the partial frame and any pending result. No output glitches beyond the reset values.

## Timing
- One entry accepted per cycle maximum. Full throughput in FILL.
- Last entry accepted at edge t: EVAL during cycle t..t+1; res_valid=1 from edge t+1.
- Result handshake at edge h: in_ready=1 from edge h. The first entry of the next frame can be accepted at edge h+1.
- Minimum frame period: cnt + 2 cycles when res_ready is held at 1.
- The tree path must settle within one clk period: it runs from the tree_in registers to the res_data capture.

## Structure
- Shared package: state enum (FILL/EVAL/HOLD) and a function computing CW from NUM.
- Single module. No sub-module is needed; the slot array is an inline generate loop. The selector tree is instantiated by the parent, not inside this block.

## Test plan
Defaults for the bench: NUM=8, LEN=16, tree model instantiated alongside.
- Reset, then idle: tree_in = all ones, in_ready=1, res_valid=0, res_data=0.
- Stream 8 entries 0x0003,0x0005,0x0008,0x0011,0x0020,0x0001,0x0002,0x0007 with no in_last, res_ready=1 → res_valid 1 cycle after the 8th accept; res_data=0x0008, res_found=1, res_count=8.
- Stream 3 entries 0x0001,0x0003,0x0009 with in_last on the 3rd → res_data=0xFFFF, res_found=0, res_count=3; slots 3..7 remain 0xFFFF.
- Hold res_ready=0 for 10 cycles with in_valid=1 → no accepts, in_ready=0, result stable. Assert res_ready → in_ready=1 the next cycle and tree_in = all ones.
- Assert rst after 4 of 8 entries → all outputs return to reset values. A following full frame 0x0010×8 gives res_data=0x0010, res_count=8.
- Back-to-back frames with res_ready=1 and in_valid=1 continuously → frame period 10 cycles. Each res_count=8, with no lost or duplicated entries.
